// File: rtl/cnt_seq_ctrl_if.sv
// Handshake and status bundle between cnt_seq_ctrl, its requester and the cnt datapath.
// The master side drives requests and the counter state, and the slave side is the sequencer.
interface cnt_seq_ctrl_if #(
    parameter int CW = 3,
    parameter int TW = 4
);
    logic          start;
    logic [CW-1:0] target;
    logic [TW-1:0] max_steps;
    logic          abort;
    logic [CW-1:0] cnt_q;
    logic          cnt_en;
    logic          cnt_clr;
    logic          busy;
    logic          done;
    logic          hit;
    logic          timeout;
    logic [TW-1:0] steps;

    modport master (
        output start, target, max_steps, abort, cnt_q,
        input  cnt_en, cnt_clr, busy, done, hit, timeout, steps
    );

    modport slave (
        input  start, target, max_steps, abort, cnt_q,
        output cnt_en, cnt_clr, busy, done, hit, timeout, steps
    );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Sequencer for the cnt datapath. It clears the counter and then steps it until cnt_q matches
// the target or the step budget is exhausted. Every output comes straight from a flop.
module cnt_seq_ctrl #(
    parameter int CW = 3,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          reset,
    cnt_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_CHECK,
        S_RUN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] target_q, target_d;
    logic [TW-1:0] max_q, max_d;
    logic [TW-1:0] steps_q, steps_d;
    logic          hit_q, hit_d;
    logic          timeout_q, timeout_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // NOTE: every signal gets its default before the case statement. Any path that skips an
    // assignment would then hold its old value, and that would infer a latch.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        max_d     = max_q;
        steps_d   = steps_q;
        hit_d     = hit_q;
        timeout_d = timeout_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    target_d  = bus.target;
                    max_d     = bus.max_steps;
                    steps_d   = '0;
                    hit_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_CHECK;
            S_CHECK: begin
                // cnt_q has settled from the previous clear or step, so it is safe to compare here.
                if (bus.abort) begin
                    hit_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (bus.cnt_q == target_q) begin
                    hit_d   = 1'b1;
                    state_d = S_DONE;
                end else if (steps_q == max_q) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                steps_d = steps_q + 1'b1;
                state_d = bus.abort ? S_DONE : S_CHECK;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that they can be registered alongside it.
        cnt_en_d  = (state_d == S_RUN);
        cnt_clr_d = (state_d == S_CLEAR);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop then samples
    // pre-edge values, whatever order the simulator evaluates the blocks in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            max_q     <= '0;
            steps_q   <= '0;
            hit_q     <= 1'b0;
            timeout_q <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            max_q     <= max_d;
            steps_q   <= steps_d;
            hit_q     <= hit_d;
            timeout_q <= timeout_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.cnt_en  = cnt_en_q;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hit     = hit_q;
    assign bus.timeout = timeout_q;
    assign bus.steps   = steps_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl. A behavioural model of the cnt datapath drives cnt_q, and each run
// is predicted by walking the counter sequence until the target is reached or the budget is spent.
module tb_cnt_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   en_cnt   = 0;
    int   clr_cnt  = 0;
    int   done_cnt = 0;

    cnt_seq_ctrl_if #(.CW(3), .TW(4)) bus ();

    cnt_seq_ctrl #(.CW(3), .TW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Counter sequence from 000: 000->011->110->101->010->111->110. Codes 001 and 100 are never reached.
    function automatic logic [2:0] cnt_next(input logic [2:0] c);
        case (c)
            3'd0:    return 3'd3;
            3'd3:    return 3'd6;
            3'd6:    return 3'd5;
            3'd5:    return 3'd2;
            3'd2:    return 3'd7;
            3'd7:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset)           bus.cnt_q <= 3'd0;
        else if (bus.cnt_clr) bus.cnt_q <= 3'd0;
        else if (bus.cnt_en)  bus.cnt_q <= cnt_next(bus.cnt_q);
    end

    always @(posedge clk) begin
        if (bus.cnt_en)  en_cnt++;
        if (bus.cnt_clr) clr_cnt++;
        if (bus.done)    done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: step the counter until it equals the target or the budget is used up.
    function automatic void model(input int tgt, input int mx, output int n, output bit h);
        logic [2:0] c = 3'd0;
        n = 0;
        while (int'(c) != tgt && n < mx) begin
            c = cnt_next(c);
            n++;
        end
        h = (int'(c) == tgt);
    endfunction

    task automatic run(input int tgt, input int mx, input bit abort_too, input bit b2b, input string tag);
        int n;
        bit h;
        int cyc;
        int en0;
        int clr0;
        model(tgt, mx, n, h);
        if (!b2b) @(negedge clk);
        bus.start     = 1'b1;
        bus.target    = 3'(tgt);
        bus.max_steps = 4'(mx);
        bus.abort     = abort_too;
        en0  = en_cnt;
        clr0 = clr_cnt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        cyc = 1;
        check({tag, "_accept"}, {bus.busy, bus.hit, bus.timeout, 28'(bus.steps)}, {3'b100, 28'd0});
        while (!bus.done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 2 * n + 3);
        check({tag, "_result"}, {bus.hit, bus.timeout, 28'(bus.steps)}, {h, !h, 28'(n)});
        @(negedge clk);
        check({tag, "_idle"}, {bus.done, bus.busy, bus.hit, bus.timeout}, {2'b00, h, !h});
        check({tag, "_pulses"}, {en_cnt - en0, clr_cnt - clr0}, {n, 32'd1});
    endtask

    task automatic wait_run(input string tag);
        int k = 0;
        while (!bus.cnt_en && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_run_seen"}, bus.cnt_en, 1'b1);
    endtask

    initial begin
        int en0;
        int d0;
        bus.start     = 1'b0;
        bus.target    = 3'd0;
        bus.max_steps = 4'd0;
        bus.abort     = 1'b0;
        reset         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.cnt_en, bus.cnt_clr, bus.done, bus.hit, bus.timeout, bus.steps}, 10'd0);
        reset = 1'b1;

        run(5, 8, 1'b0, 1'b0, "s1");
        run(0, 5, 1'b0, 1'b0, "s2");
        run(1, 8, 1'b0, 1'b0, "s3");

        // Abort two cycles after RUN is first entered, and pulse start while busy.
        @(negedge clk);
        bus.start = 1'b1; bus.target = 3'd1; bus.max_steps = 4'd15;
        en0 = en_cnt;
        @(negedge clk);
        bus.start = 1'b0;
        wait_run("s4");
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("s4_run_again", bus.cnt_en, 1'b1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("s4_done", {bus.done, bus.hit, bus.timeout, bus.cnt_en, bus.steps}, {4'b1000, 4'd2});
        repeat (4) @(negedge clk);
        check("s4_no_queue", {bus.busy, bus.done}, 2'b00);
        check("s4_en_total", en_cnt - en0, 2);

        // Abort in CHECK ends the run after the single step already issued.
        @(negedge clk);
        bus.start = 1'b1; bus.target = 3'd4; bus.max_steps = 4'd15;
        @(negedge clk);
        bus.start = 1'b0;
        wait_run("s4b");
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("s4b_done", {bus.done, bus.hit, bus.timeout, bus.steps}, {3'b100, 4'd1});

        // Asynchronous reset between clock edges in the middle of a run.
        run(7, 8, 1'b0, 1'b0, "pre5");
        @(negedge clk);
        bus.start = 1'b1; bus.target = 3'd5; bus.max_steps = 4'd8;
        @(negedge clk);
        bus.start = 1'b0;
        wait_run("s5");
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        check("s5_async", {bus.busy, bus.cnt_en, bus.cnt_clr, bus.done, bus.hit, bus.timeout, bus.steps}, 10'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_no_done", done_cnt - d0, 0);
        run(5, 8, 1'b0, 1'b0, "s5_rerun");

        // A zero budget times out, and a back-to-back start clears the previous flags.
        run(3, 0, 1'b0, 1'b0, "s6");
        run(5, 8, 1'b0, 1'b1, "s6_b2b");
        run(0, 0, 1'b0, 1'b1, "s6_zero_hit");

        for (int i = 0; i < 20; i++) begin
            run(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
